// File: rtl/irq_chain_node.sv
// Multi-channel interrupt source node for the daisy-chained priority bus.
// Optional ack timeout is enabled by defining IRQ_ACK_TIMEOUT_EN.
module irq_chain_node #(
  parameter int unsigned         NUM_CH      = 4,
  parameter int unsigned         VEC_W       = 8,
  parameter logic [VEC_W-1:0]    BASE_VECTOR = VEC_W'(8'h20),
  parameter int unsigned         LEVEL_W     = 4,
  parameter logic [LEVEL_W-1:0]  BASE_LEVEL  = LEVEL_W'(4'd0),
  parameter int unsigned         ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CH-1:0]  irq_in,
  input  logic               mask_we,
  input  logic [NUM_CH-1:0]  mask_wdata,
  input  logic               chain_pi,
  output logic               chain_po,
  input  logic               ack_in,
  output logic               ack_out,
  input  logic               eoi_in,
  output logic               int_req,
  output logic [VEC_W-1:0]   vector_out,
  output logic [LEVEL_W-1:0] level_out,
  output logic               vector_valid,
  output logic               in_service,
  output logic               timeout_flag
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_ACK     = 2'd2;
  localparam logic [1:0] S_SERVICE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [NUM_CH-1:0]  irq_q;
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [CH_W-1:0]    sel_ch_q, sel_ch_d;
  logic               int_req_q, int_req_d;
  logic [VEC_W-1:0]   vector_q, vector_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               vvalid_q, vvalid_d;
  logic               in_service_q, in_service_d;

  logic [NUM_CH-1:0]  rise_c;
  logic [NUM_CH-1:0]  active_c;
  logic [NUM_CH-1:0]  clr_c;
  logic [CH_W-1:0]    prio_c;
  logic [CH_W-1:0]    sel_ch_c;
  logic               selecting_c;

  assign rise_c      = irq_in & ~irq_q;
  assign active_c    = pending_q & ~mask_q;
  assign selecting_c = (state_q == S_IDLE) || (state_q == S_REQ);
  // Selection tracks active while arbitrating, then stays frozen through service.
  assign sel_ch_c    = selecting_c ? prio_c : sel_ch_q;

  // Fixed priority: lowest active index wins.
  always_comb begin
    prio_c = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (active_c[i]) prio_c = CH_W'(i);
    end
  end

`ifdef IRQ_ACK_TIMEOUT_EN
  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             timeout_hit_c;

  assign timeout_hit_c = (state_q == S_REQ) && (|active_c) && !(ack_in && chain_pi)
                         && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    clr_c    = '0;
    sel_ch_d = sel_ch_q;
    vector_d = vector_q;
    level_d  = level_q;

    case (state_q)
      S_IDLE: begin
        sel_ch_d = sel_ch_c;
        if (|active_c) state_d = S_REQ;
      end
      S_REQ: begin
        sel_ch_d = sel_ch_c;
        if (!(|active_c)) begin
          state_d = S_IDLE;
        end else if (ack_in && chain_pi) begin
          state_d  = S_ACK;
          clr_c    = NUM_CH'(1) << sel_ch_c;
          vector_d = BASE_VECTOR + VEC_W'(sel_ch_c);
          level_d  = BASE_LEVEL + LEVEL_W'(sel_ch_c);
        end
`ifdef IRQ_ACK_TIMEOUT_EN
        else if (timeout_hit_c) begin
          state_d = S_IDLE;
          clr_c   = NUM_CH'(1) << sel_ch_c;
        end
`endif
      end
      S_ACK: begin
        state_d = S_SERVICE;
      end
      S_SERVICE: begin
        if (eoi_in) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A fresh edge on the channel being cleared keeps it pending.
    pending_d    = (pending_q & ~clr_c) | rise_c;
    mask_d       = mask_we ? mask_wdata : mask_q;
    int_req_d    = (state_d == S_REQ);
    vvalid_d     = (state_d == S_ACK);
    in_service_d = (state_d == S_SERVICE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      irq_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      sel_ch_q     <= '0;
      int_req_q    <= 1'b0;
      vector_q     <= '0;
      level_q      <= '0;
      vvalid_q     <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_in;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      sel_ch_q     <= sel_ch_d;
      int_req_q    <= int_req_d;
      vector_q     <= vector_d;
      level_q      <= level_d;
      vvalid_q     <= vvalid_d;
      in_service_q <= in_service_d;
    end
  end

`ifdef IRQ_ACK_TIMEOUT_EN
  // Counter restarts on every REQ entry; flag is sticky until reset.
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q | timeout_hit_c;
    if ((state_q == S_REQ) && (state_d == S_REQ)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = ^(32'(ACK_TIMEOUT));
  assign timeout_flag       = 1'b0;
`endif

  assign chain_po     = chain_pi && (state_q == S_IDLE) && !(|active_c);
  assign ack_out      = ack_in && !((state_q == S_REQ) && chain_pi);
  assign int_req      = int_req_q;
  assign vector_out   = vector_q;
  assign level_out    = level_q;
  assign vector_valid = vvalid_q;
  assign in_service   = in_service_q;

endmodule

// File: tb/tb_irq_chain_node.sv
// Scoreboard bench for irq_chain_node: grants are checked by a monitor against queued vectors.
module tb_irq_chain_node;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       chain_pi;
  logic       chain_po;
  logic       ack_in;
  logic       ack_out;
  logic       eoi_in;
  logic       int_req;
  logic [7:0] vector_out;
  logic [3:0] level_out;
  logic       vector_valid;
  logic       in_service;
  logic       timeout_flag;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] vec;
    logic [3:0] lvl;
  } grant_t;

  grant_t exp_q[$];

  irq_chain_node dut (
    .clk          (clk),
    .reset        (reset),
    .irq_in       (irq_in),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .chain_pi     (chain_pi),
    .chain_po     (chain_po),
    .ack_in       (ack_in),
    .ack_out      (ack_out),
    .eoi_in       (eoi_in),
    .int_req      (int_req),
    .vector_out   (vector_out),
    .level_out    (level_out),
    .vector_valid (vector_valid),
    .in_service   (in_service),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every vector_valid strobe must match the oldest expected grant.
  always @(negedge clk) begin
    if (!reset && vector_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(vector_out), 32'hFFFF_FFFF);
      end else begin
        grant_t g;
        g = exp_q.pop_front();
        check("grant_vector", 32'(vector_out), 32'(g.vec));
        check("grant_level", 32'(level_out), 32'(g.lvl));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse request lines, then confirm int_req rises one cycle after capture.
  task automatic go_req(input logic [3:0] m);
    irq_in = m;
    tick();
    irq_in = 4'b0;
    check("int_req_not_yet", 32'(int_req), 32'd0);
    check("chain_po_pending", 32'(chain_po), 32'd0);
    tick();
    check("int_req_rise", 32'(int_req), 32'd1);
  endtask

  task automatic grant(input logic [7:0] vec, input logic [3:0] lvl);
    grant_t g;
    g.vec = vec;
    g.lvl = lvl;
    exp_q.push_back(g);
    ack_in = 1'b1;
    #1;
    check("ack_out_claimed", 32'(ack_out), 32'd0);
    tick();
    ack_in = 1'b0;
    check("vv_high", 32'(vector_valid), 32'd1);
    check("int_req_drop", 32'(int_req), 32'd0);
    tick();
    check("vv_one_cycle", 32'(vector_valid), 32'd0);
    check("in_service", 32'(in_service), 32'd1);
    check("chain_po_svc", 32'(chain_po), 32'd0);
  endtask

  task automatic eoi();
    eoi_in = 1'b1;
    tick();
    eoi_in = 1'b0;
    check("eoi_idle", 32'(in_service), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    irq_in     = 4'b0;
    mask_we    = 1'b0;
    mask_wdata = 4'b0;
    chain_pi   = 1'b1;
    ack_in     = 1'b0;
    eoi_in     = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_vector", 32'(vector_out), 32'd0);
    check("rst_level", 32'(level_out), 32'd0);
    check("rst_vv", 32'(vector_valid), 32'd0);
    check("rst_in_service", 32'(in_service), 32'd0);
    check("rst_timeout", 32'(timeout_flag), 32'd0);
    check("rst_chain_po", 32'(chain_po), 32'd1);
    tick();

    // Single channel 2 request through EOI
    go_req(4'b0100);
    grant(8'h22, 4'd2);
    repeat (3) tick();
    check("svc_hold", 32'(in_service), 32'd1);
    check("svc_chain_po", 32'(chain_po), 32'd0);
    check("vec_hold", 32'(vector_out), 32'h22);
    eoi();
    check("chain_po_free", 32'(chain_po), 32'd1);

    // Simultaneous ch3 and ch1: ch1 first, then re-request for ch3
    go_req(4'b1010);
    grant(8'h21, 4'd1);
    eoi();
    check("rereq_idle", 32'(int_req), 32'd0);
    tick();
    check("rereq", 32'(int_req), 32'd1);
    grant(8'h23, 4'd3);
    eoi();

    // Upstream owns the ack: no grant while chain_pi is low
    go_req(4'b0001);
    chain_pi = 1'b0;
    ack_in   = 1'b1;
    #1;
    check("ack_pass", 32'(ack_out), 32'd1);
    check("chain_po_blocked", 32'(chain_po), 32'd0);
    tick();
    check("hold_req", 32'(int_req), 32'd1);
    check("no_vv", 32'(vector_valid), 32'd0);
    ack_in   = 1'b0;
    chain_pi = 1'b1;
    tick();
    grant(8'h20, 4'd0);
    eoi();

    // Mask the only pending channel while requesting, then unmask
    go_req(4'b0001);
    mask_we    = 1'b1;
    mask_wdata = 4'b0001;
    tick();
    mask_we = 1'b0;
    check("mask_req_still", 32'(int_req), 32'd1);
    tick();
    check("masked_drop", 32'(int_req), 32'd0);
    check("masked_chain_po", 32'(chain_po), 32'd1);
    tick();
    check("masked_stay", 32'(int_req), 32'd0);
    mask_we    = 1'b1;
    mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b0;
    tick();
    check("unmask_req", 32'(int_req), 32'd1);
    grant(8'h20, 4'd0);
    eoi();

    // New ch1 edge coinciding with the ch1 grant keeps it pending
    go_req(4'b0010);
    irq_in = 4'b0010;
    grant(8'h21, 4'd1);
    irq_in = 4'b0000;
    eoi();
    tick();
    check("edge_wins_req", 32'(int_req), 32'd1);
    grant(8'h21, 4'd1);
    eoi();
    tick();
    check("quiet", 32'(int_req), 32'd0);

`ifdef IRQ_ACK_TIMEOUT_EN
    // No ack: timeout after 16 REQ cycles
    go_req(4'b0100);
    repeat (15) tick();
    check("to_still_req", 32'(int_req), 32'd1);
    check("to_flag_low", 32'(timeout_flag), 32'd0);
    tick();
    check("to_drop", 32'(int_req), 32'd0);
    check("to_flag", 32'(timeout_flag), 32'd1);
    check("to_cleared", 32'(chain_po), 32'd1);
    tick();
    check("to_idle", 32'(int_req), 32'd0);
    check("to_sticky", 32'(timeout_flag), 32'd1);
`else
    // Without the timeout the request waits indefinitely
    go_req(4'b0100);
    repeat (20) tick();
    check("wait_req", 32'(int_req), 32'd1);
    check("no_timeout", 32'(timeout_flag), 32'd0);
    grant(8'h22, 4'd2);
    eoi();
`endif

    // Reset asserted in SERVICE clears all outputs immediately
    go_req(4'b1000);
    grant(8'h23, 4'd3);
    #2 reset = 1'b1;
    #1;
    check("mrst_int_req", 32'(int_req), 32'd0);
    check("mrst_vector", 32'(vector_out), 32'd0);
    check("mrst_level", 32'(level_out), 32'd0);
    check("mrst_vv", 32'(vector_valid), 32'd0);
    check("mrst_in_service", 32'(in_service), 32'd0);
    check("mrst_timeout", 32'(timeout_flag), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_int_req", 32'(int_req), 32'd0);
    check("post_rst_svc", 32'(in_service), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
